// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-protocol master.
//   FRAME_BITS : bits per frame (8-bit header + 8-bit data)
//   HDR_WR_BIT : header bit carrying the write flag
//   ADDR_W     : register address width (header[3:0])
//   DATA_W     : data byte width
//   spi_state_e: master FSM states
//   build_frame: assembles {wr,3'b000,addr,data}; reads send 8'h00 as data
package spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam int HDR_WR_BIT = 7;
   localparam int ADDR_W     = 4;
   localparam int DATA_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      GAP
   } spi_state_e;

   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic              wr,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] hdr;
      logic [DATA_W-1:0] dat;
      hdr             = '0;
      hdr[HDR_WR_BIT] = wr;
      hdr[ADDR_W-1:0] = addr;
      dat             = wr ? wdata : '0;
      return {hdr, dat};
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   clr       : synchronous clear, holds the count at zero
//   en        : count enable (master is inside a frame)
//   phase_end : 1-cycle pulse on the last clk cycle of each CLK_DIV-cycle phase
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic phase_end
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   assign phase_end = en && (div_cnt == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for the 16-bit register-slave protocol (header then data, MSB first).
//   clk, rst            : system clock, synchronous active-high reset
//   start               : command strobe, taken only while not busy
//   cmd_write/addr/wdata: command fields, captured at acceptance
//   busy                : frame or inter-frame gap in progress
//   done                : 1-cycle pulse at frame completion
//   rd_status, rd_data  : miso bits 15..8 and 7..0 of the last completed frame
//   spi_clk/cs/mosi/miso: SPI pins (clock idles low, cs active low)
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_status,
   output logic [DATA_W-1:0] rd_data,
   output logic              spi_clk,
   output logic              spi_cs,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int            GW       = $clog2(CS_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
   localparam logic [4:0]    NBITS    = 5'(FRAME_BITS);

   spi_state_e            state;
   logic [FRAME_BITS-1:0] shift_tx;
   logic [FRAME_BITS-1:0] shift_rx;
   logic [FRAME_BITS-1:0] tx_frame;
   logic [FRAME_BITS-1:0] rx_next;
   logic [4:0]            bit_cnt;
   logic [GW-1:0]         gap_cnt;
   logic                  div_en;
   logic                  phase_end;

   assign tx_frame = build_frame(cmd_write, cmd_addr, cmd_wdata);
   // Includes the bit being sampled this cycle so the frame-end capture sees all 16.
   assign rx_next  = {shift_rx[FRAME_BITS-2:0], spi_miso};
   assign div_en   = (state == LEAD) || (state == HIGH) || (state == LOW);

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk       (clk),
      .rst       (rst),
      .clr       (!div_en),
      .en        (div_en),
      .phase_end (phase_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         spi_cs    <= 1'b1;
         spi_clk   <= 1'b0;
         spi_mosi  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_status <= '0;
         rd_data   <= '0;
         shift_tx  <= '0;
         shift_rx  <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !busy) begin
                  shift_tx <= tx_frame;
                  spi_mosi <= tx_frame[FRAME_BITS-1];
                  spi_cs   <= 1'b0;
                  busy     <= 1'b1;
                  bit_cnt  <= '0;
                  state    <= LEAD;
               end
            end
            LEAD: begin
               if (phase_end) begin
                  spi_clk <= 1'b1;
                  state   <= HIGH;
               end
            end
            HIGH: begin
               // Falling edge: the only place mosi advances.
               if (phase_end) begin
                  spi_clk  <= 1'b0;
                  if (bit_cnt < NBITS) bit_cnt <= bit_cnt + 1'b1;
                  shift_tx <= {shift_tx[FRAME_BITS-2:0], 1'b0};
                  spi_mosi <= shift_tx[FRAME_BITS-2];
                  state    <= LOW;
               end
            end
            LOW: begin
               // Sample late in the low phase so the slave's drive lag has settled.
               if (phase_end) begin
                  shift_rx <= rx_next;
                  if (bit_cnt < NBITS) begin
                     spi_clk <= 1'b1;
                     state   <= HIGH;
                  end else begin
                     spi_cs    <= 1'b1;
                     spi_mosi  <= 1'b0;
                     rd_status <= rx_next[FRAME_BITS-1:DATA_W];
                     rd_data   <= rx_next[DATA_W-1:0];
                     done      <= 1'b1;
                     gap_cnt   <= '0;
                     state     <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench: two masters (CLK_DIV=4/CS_GAP=4 and CLK_DIV=8/CS_GAP=2), each wired to
// a behavioural register slave (status byte 8'h5C). A frame-timeline model predicts
// every output each cycle; directed scenarios add hand-computed expectations.
module tb_spi_master_ctrl;

   localparam int NI = 2;

   logic clk = 1'b0;
   logic rst;
   logic [NI-1:0]       start, cmd_write, busy, done, spi_clk, spi_cs, spi_mosi, spi_miso;
   logic [NI-1:0][3:0]  cmd_addr;
   logic [NI-1:0][7:0]  cmd_wdata, rd_status, rd_data;

   always #5 clk = ~clk;

   spi_master_ctrl #(.CLK_DIV(4), .CS_GAP(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start[0]), .cmd_write(cmd_write[0]),
      .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]), .busy(busy[0]), .done(done[0]),
      .rd_status(rd_status[0]), .rd_data(rd_data[0]), .spi_clk(spi_clk[0]),
      .spi_cs(spi_cs[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0])
   );

   spi_master_ctrl #(.CLK_DIV(8), .CS_GAP(2)) u_dut8 (
      .clk(clk), .rst(rst), .start(start[1]), .cmd_write(cmd_write[1]),
      .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]), .busy(busy[1]), .done(done[1]),
      .rd_status(rd_status[1]), .rd_data(rd_data[1]), .spi_clk(spi_clk[1]),
      .spi_cs(spi_cs[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1])
   );

   function automatic int divof(input int g);
      return (g == 0) ? 4 : 8;
   endfunction
   function automatic int gapof(input int g);
      return (g == 0) ? 4 : 2;
   endfunction

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   bit started = 0;

   // reference model
   bit         m_act [NI];
   int         m_t0 [NI];
   logic [15:0] m_stream [NI];
   logic        m_wr [NI];
   logic [3:0]  m_addr [NI];
   logic [7:0]  m_wd [NI], m_pdata [NI], m_rdst [NI], m_rdd [NI];
   logic [7:0]  m_regs [NI][16];

   // slave
   logic        s_prev [NI];
   int          s_rcnt [NI], s_fcnt [NI];
   logic [15:0] s_rx [NI];
   logic [7:0]  s_hdr [NI];
   logic [7:0]  s_regs [NI][16];

   // pin monitor
   int          redges [NI], ndone [NI], ncsf [NI], done_cyc [NI];
   int          last_gap [NI], last_cslow [NI], last_dw [NI];
   int          lo_run [NI], hi_run [NI], dw_run [NI];
   logic [15:0] cap [NI];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic slave_mon(input int g);
      logic sc, cs;
      logic [15:0] w;
      int n;
      sc = spi_clk[g];
      cs = spi_cs[g];
      if (cs !== 1'b0) begin
         s_rcnt[g] = 0;
         s_fcnt[g] = 0;
      end else begin
         if (sc && !s_prev[g]) begin
            s_rx[g] = {s_rx[g][14:0], spi_mosi[g]};
            s_rcnt[g]++;
            if (s_rcnt[g] == 8) s_hdr[g] = s_rx[g][7:0];
            if (s_rcnt[g] == 16 && s_rx[g][15]) s_regs[g][s_rx[g][11:8]] = s_rx[g][7:0];
            redges[g]++;
            cap[g] = {cap[g][14:0], spi_mosi[g]};
         end
         if (!sc && s_prev[g]) begin
            s_fcnt[g]++;
            n = s_fcnt[g];
            if (n <= 16) begin
               w = {8'h5C, (s_hdr[g][7] ? 8'h00 : s_regs[g][s_hdr[g][3:0]])};
               spi_miso[g] = w[16-n];
            end
         end
      end
      s_prev[g] = sc;
      if (cs === 1'b0) begin
         if (hi_run[g] > 0) begin last_gap[g] = hi_run[g]; hi_run[g] = 0; ncsf[g]++; end
         lo_run[g]++;
      end else begin
         if (lo_run[g] > 0) begin last_cslow[g] = lo_run[g]; lo_run[g] = 0; end
         hi_run[g]++;
      end
      if (done[g] === 1'b1) begin
         ndone[g]++; done_cyc[g] = cyc; dw_run[g]++;
      end else if (dw_run[g] > 0) begin
         last_dw[g] = dw_run[g]; dw_run[g] = 0;
      end
   endtask

   task automatic compare(input int g);
      int d, gp, r, j;
      bit inf;
      d = divof(g); gp = gapof(g);
      r = cyc - m_t0[g];
      inf = m_act[g] && r >= 1 && r <= 33*d;
      j = inf ? (r - 1) / d : 0;
      chk($sformatf("u%0d spi_cs", g),  32'(spi_cs[g]),  32'(!inf));
      chk($sformatf("u%0d spi_clk", g), 32'(spi_clk[g]), 32'(inf && (j % 2 == 1)));
      chk($sformatf("u%0d busy", g),    32'(busy[g]),    32'(m_act[g] && r >= 1 && r <= 33*d + gp));
      chk($sformatf("u%0d done", g),    32'(done[g]),    32'(m_act[g] && r == 33*d + 1));
      chk($sformatf("u%0d rd_status", g), 32'(rd_status[g]), 32'(m_rdst[g]));
      chk($sformatf("u%0d rd_data", g),   32'(rd_data[g]),   32'(m_rdd[g]));
      if (inf && j < 32)
         chk($sformatf("u%0d spi_mosi", g), 32'(spi_mosi[g]), 32'(m_stream[g][15 - j/2]));
   endtask

   task automatic model_update();
      for (int g = 0; g < NI; g++) begin
         int d, gp, r;
         bit idle;
         d = divof(g); gp = gapof(g);
         r = cyc - m_t0[g];
         idle = !m_act[g] || r > 33*d + gp;
         if (rst) begin
            m_act[g] = 0; m_rdst[g] = 8'h00; m_rdd[g] = 8'h00;
         end else begin
            if (m_act[g] && r == 33*d) begin
               m_rdst[g] = 8'h5C;
               m_rdd[g]  = m_pdata[g];
               if (m_wr[g]) m_regs[g][m_addr[g]] = m_wd[g];
            end
            if (idle && start[g]) begin
               m_act[g]    = 1;
               m_t0[g]     = cyc;
               m_wr[g]     = cmd_write[g];
               m_addr[g]   = cmd_addr[g];
               m_wd[g]     = cmd_wdata[g];
               m_pdata[g]  = cmd_write[g] ? 8'h00 : m_regs[g][cmd_addr[g]];
               m_stream[g] = {cmd_write[g], 3'b000, cmd_addr[g], (cmd_write[g] ? cmd_wdata[g] : 8'h00)};
            end else if (idle) begin
               m_act[g] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (started) begin
         for (int g = 0; g < NI; g++) begin
            slave_mon(g);
            compare(g);
         end
      end
      @(posedge clk);
      model_update();
      cyc++;
      started = 1;
      #1;
   endtask

   task automatic wait_idle(input int g);
      for (int i = 0; i < 2000 && busy[g] !== 1'b0; i++) tick();
   endtask

   task automatic issue(input int g, input logic wr, input logic [3:0] a, input logic [7:0] d,
                        output int st);
      wait_idle(g);
      cmd_write[g] = wr; cmd_addr[g] = a; cmd_wdata[g] = d;
      start[g] = 1'b1;
      st = cyc;
      tick();
      start[g] = 1'b0;
      cmd_wdata[g] = ~d;          // later changes must not reach the frame
   endtask

   task automatic wait_done(input int g, input int base);
      for (int i = 0; i < 1000 && ndone[g] <= base; i++) tick();
      chk($sformatf("u%0d done seen within bound", g), 32'(ndone[g] > base), 32'd1);
      repeat (2) tick();
   endtask

   // Directed write-then-read pair; expected figures depend only on CLK_DIV.
   task automatic write_read_pair(input int g);
      int st, b, r0, d;
      d = divof(g);
      b = ndone[g];
      issue(g, 1'b1, 4'd3, 8'hA5, st);
      wait_done(g, b);
      chk($sformatf("u%0d t1 mosi stream", g), 32'(cap[g]), 32'h83A5);
      chk($sformatf("u%0d t1 rd_status", g), 32'(rd_status[g]), 32'h5C);
      chk($sformatf("u%0d t1 rd_data", g), 32'(rd_data[g]), 32'h00);
      chk($sformatf("u%0d t1 done latency", g), 32'(done_cyc[g] - st), (g == 0) ? 32'd133 : 32'd265);
      chk($sformatf("u%0d t1 done width", g), 32'(last_dw[g]), 32'd1);
      chk($sformatf("u%0d t1 cs low width", g), 32'(last_cslow[g]), (g == 0) ? 32'd132 : 32'd264);
      b = ndone[g]; r0 = redges[g];
      issue(g, 1'b0, 4'd3, 8'h77, st);
      wait_done(g, b);
      chk($sformatf("u%0d t2 mosi stream", g), 32'(cap[g]), 32'h0300);
      chk($sformatf("u%0d t2 rd_status", g), 32'(rd_status[g]), 32'h5C);
      chk($sformatf("u%0d t2 rd_data", g), 32'(rd_data[g]), 32'hA5);
      chk($sformatf("u%0d t2 rising edges", g), 32'(redges[g] - r0), 32'd16);
      chk($sformatf("u%0d t2 cs low width", g), 32'(last_cslow[g]), 32'(33 * d));
   endtask

   task automatic reset_after_edges(input int g, input int r0, input int k);
      for (int i = 0; i < 1000 && redges[g] < r0 + k; i++) tick();
      chk($sformatf("u%0d edge wait within bound", g), 32'(redges[g] >= r0 + k), 32'd1);
      rst = 1'b1;
      tick();
      chk($sformatf("u%0d spi_cs after reset", g), 32'(spi_cs[g]), 32'd1);
      chk($sformatf("u%0d spi_clk after reset", g), 32'(spi_clk[g]), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      int st, b, f, r0;
      rst = 1'b1;
      start = '0; cmd_write = '0; cmd_addr = '0; cmd_wdata = '0; spi_miso = '0;
      for (int g = 0; g < NI; g++) begin
         m_act[g] = 0; m_t0[g] = 0; m_stream[g] = '0; m_wr[g] = 0; m_addr[g] = '0;
         m_wd[g] = '0; m_pdata[g] = '0; m_rdst[g] = '0; m_rdd[g] = '0;
         s_prev[g] = 0; s_rcnt[g] = 0; s_fcnt[g] = 0; s_rx[g] = '0; s_hdr[g] = '0;
         redges[g] = 0; ndone[g] = 0; ncsf[g] = 0; done_cyc[g] = 0; last_gap[g] = 0;
         last_cslow[g] = 0; last_dw[g] = 0; lo_run[g] = 0; hi_run[g] = 0; dw_run[g] = 0;
         cap[g] = '0;
         for (int a = 0; a < 16; a++) begin m_regs[g][a] = '0; s_regs[g][a] = '0; end
      end
      repeat (3) tick();
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("u%0d reset spi_cs", g), 32'(spi_cs[g]), 32'd1);
         chk($sformatf("u%0d reset spi_clk", g), 32'(spi_clk[g]), 32'd0);
         chk($sformatf("u%0d reset spi_mosi", g), 32'(spi_mosi[g]), 32'd0);
         chk($sformatf("u%0d reset busy", g), 32'(busy[g]), 32'd0);
         chk($sformatf("u%0d reset rd_data", g), 32'(rd_data[g]), 32'd0);
      end
      // start coincident with reset must be ignored
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      chk("u0 start during reset", 32'(busy[0]), 32'd0);
      rst = 1'b0;
      tick();

      // tests 1-2
      write_read_pair(0);

      // test 3: second start 10 cycles in is dropped
      b = ndone[0]; f = ncsf[0];
      issue(0, 1'b0, 4'd3, 8'h00, st);
      repeat (9) tick();
      cmd_write[0] = 1'b1; cmd_wdata[0] = 8'h00; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (300) tick();
      chk("u0 t3 done count", 32'(ndone[0] - b), 32'd1);
      chk("u0 t3 frame count", 32'(ncsf[0] - f), 32'd1);
      chk("u0 t3 rd_data", 32'(rd_data[0]), 32'hA5);

      // test 4: reset after the 5th rising edge of a write
      b = ndone[0]; r0 = redges[0];
      issue(0, 1'b1, 4'd3, 8'h3C, st);
      reset_after_edges(0, r0, 5);
      repeat (150) tick();
      chk("u0 t4 no done after abort", 32'(ndone[0] - b), 32'd0);
      b = ndone[0];
      issue(0, 1'b0, 4'd3, 8'h00, st);
      wait_done(0, b);
      chk("u0 t4 read after abort", 32'(rd_data[0]), 32'hA5);

      // test 5: start held for three frames
      wait_idle(0);
      b = ndone[0]; f = ncsf[0];
      cmd_write[0] = 1'b0; cmd_addr[0] = 4'd3; start[0] = 1'b1;
      for (int i = 0; i < 2000 && ncsf[0] < f + 2; i++) tick();
      chk("u0 t5 gap 1", 32'(last_gap[0]), 32'd5);
      for (int i = 0; i < 2000 && ncsf[0] < f + 3; i++) tick();
      start[0] = 1'b0;
      chk("u0 t5 gap 2", 32'(last_gap[0]), 32'd5);
      repeat (400) tick();
      chk("u0 t5 done count", 32'(ndone[0] - b), 32'd3);

      // test 6: slower divider, shorter gap
      write_read_pair(1);

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         int g, k;
         logic wr;
         logic [3:0] a;
         logic [7:0] d;
         g  = int'($urandom_range(0, 3) == 0);
         wr = 1'($urandom_range(0, 1));
         a  = 4'($urandom_range(0, 3));
         d  = 8'($urandom);
         b  = ndone[g]; r0 = redges[g];
         issue(g, wr, a, d, st);
         if ($urandom_range(0, 9) == 0) begin
            k = int'($urandom_range(1, 12));
            reset_after_edges(g, r0, k);
         end else begin
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 20)) tick();
               cmd_write[g] = ~wr; start[g] = 1'b1;
               tick();
               start[g] = 1'b0;
            end
            wait_done(g, b);
            chk($sformatf("u%0d rnd mosi stream", g), 32'(cap[g]),
                32'({wr, 3'b000, a, (wr ? d : 8'h00)}));
         end
         repeat ($urandom_range(0, 6)) tick();
      end

      repeat (300) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
